// File: rtl/pdm_adc_if.sv
// PCM output channel of the PDM demodulator: sample handshake plus the sticky overrun flag.
interface pdm_adc_if #(
  parameter int SAMPLE_BITS = 12
);
  logic signed [SAMPLE_BITS-1:0] sample;
  logic                          sample_valid;
  logic                          sample_ready;
  logic                          overrun;
  logic                          overrun_clr;

  modport master (
    output sample, sample_valid, overrun,
    input  sample_ready, overrun_clr
  );

  modport slave (
    input  sample, sample_valid, overrun,
    output sample_ready, overrun_clr
  );
endinterface

// File: rtl/pdm_adc.sv
// PDM receive demodulator: drives pdm_clk, samples the 1-bit stream on each pdm_clk fall and
// boxcar-decimates 2**LOG2_DEC bits into one signed PCM sample with a valid/ready output.
module pdm_adc #(
  parameter int SAMPLE_BITS = 12,
  parameter int LOG2_DEC    = 6,
  parameter int CLK_DIV     = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  output logic       pdm_clk,
  input  logic       pdm_in,
  pdm_adc_if.master  bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW    = SAMPLE_BITS + 2;
  localparam int SHIFT = SAMPLE_BITS - LOG2_DEC;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic signed [CW-1:0] HALF     = CW'(2 ** (SAMPLE_BITS - 1));
  localparam logic signed [CW-1:0] MAX_V    = CW'(2 ** (SAMPLE_BITS - 1) - 1);

  logic                          sync1, sync2;
  logic [DIV_W-1:0]              div_cnt;
  logic [LOG2_DEC-1:0]           bit_cnt;
  logic [LOG2_DEC:0]             ones;
  logic [LOG2_DEC:0]             total;
  logic                          div_wrap, bit_stb, win_done;
  logic signed [CW-1:0]          shifted, centered;
  logic signed [SAMPLE_BITS-1:0] sat_val;

  assign div_wrap = enable && (div_cnt == DIV_LAST);
  assign bit_stb  = div_wrap && pdm_clk;
  assign win_done = bit_stb && (bit_cnt == {LOG2_DEC{1'b1}});
  assign total    = ones + {{LOG2_DEC{1'b0}}, sync2};

  // Only an all-ones window lands above full scale; nothing can fall below it.
  always_comb begin
    shifted  = $signed({{(CW-LOG2_DEC-1){1'b0}}, total}) <<< SHIFT;
    centered = shifted - HALF;
    sat_val  = centered[SAMPLE_BITS-1:0];
    if (centered > MAX_V) sat_val = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pdm_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
      bit_cnt <= '0;
      ones    <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
      bit_cnt <= '0;
      ones    <= '0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        pdm_clk <= ~pdm_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      // bit_cnt wraps to zero on its own at the end of a window.
      if (bit_stb) begin
        bit_cnt <= bit_cnt + 1'b1;
        ones    <= win_done ? '0 : total;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      if (win_done) begin
        bus.sample       <= sat_val;
        bus.sample_valid <= 1'b1;
      end else if (bus.sample_valid && bus.sample_ready) begin
        bus.sample_valid <= 1'b0;
      end
      if (win_done && bus.sample_valid && !bus.sample_ready) bus.overrun <= 1'b1;
      else if (bus.overrun_clr)                               bus.overrun <= 1'b0;
    end
  end
endmodule
